// File: rtl/chia8_pkg.sv
// Shared widths, constants and FSM encoding for the chia8 sequential divider.
package chia8_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;

    localparam logic [4:0]            ITER_LAST = 5'd15;
    localparam logic [DIVIDEND_W-1:0] Q_DZ      = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chia8_if.sv
// Start/busy/done handshake and result bus between ALU control and the divider.
// Handshake: start is sampled only while busy=0; done is a one-cycle pulse and
// Q/R/ov/dz are valid from that cycle until the next accepted start.
interface chia8_if;
    import chia8_pkg::*;

    logic                  start;
    logic [DIVIDEND_W-1:0] A;
    logic [DIVISOR_W-1:0]  B;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] Q;
    logic [DIVISOR_W-1:0]  R;
    logic                  ov;
    logic                  dz;
    state_t                state;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, ov, dz, state
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, ov, dz, state
    );

endinterface

// File: rtl/chia8_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract B.
module chia8_step
    import chia8_pkg::*;
(
    input  logic [8:0]           p,
    input  logic                 msb,
    input  logic [DIVISOR_W-1:0] b,
    output logic [8:0]           p_next,
    output logic                 qbit
);

    logic [9:0] t;
    logic [9:0] diff;

    // P stays below B, so t never exceeds 509 and the borrow bit is exact.
    assign t    = {p, msb};
    assign diff = t - {2'b00, b};
    assign qbit = ~diff[9];

    assign p_next = qbit ? diff[8:0] : t[8:0];

endmodule

// File: rtl/chia8.sv
// 16/8 unsigned restoring divider, one quotient bit per clock, with overflow
// and divide-by-zero flags matching the neighbouring 8x8 multiplier.
module chia8
    import chia8_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    chia8_if.slave bus
);

    state_t                state_q;
    state_t                state_d;
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [8:0]            p_q;
    logic [8:0]            p_next;
    logic                  qbit;
    logic [4:0]            cnt_q;
    logic [DIVIDEND_W-1:0] q_q;
    logic [DIVIDEND_W-1:0] q_next;
    logic [DIVISOR_W-1:0]  r_q;
    logic                  ov_q;
    logic                  dz_q;
    logic                  accept;
    logic                  b_zero;
    logic                  last_iter;

    assign accept    = (state_q == IDLE) && bus.start;
    assign b_zero    = (bus.B == '0);
    assign last_iter = (cnt_q == ITER_LAST);
    assign q_next    = {q_q[DIVIDEND_W-2:0], qbit};

    chia8_step u_step (
        .p      (p_q),
        .msb    (dvd_q[DIVIDEND_W-1]),
        .b      (dvs_q),
        .p_next (p_next),
        .qbit   (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q <= '0;
            dvs_q <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            ov_q  <= 1'b0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            if (b_zero) begin
                q_q  <= Q_DZ;
                r_q  <= bus.A[DIVISOR_W-1:0];
                ov_q <= 1'b1;
                dz_q <= 1'b1;
            end else begin
                dvd_q <= bus.A;
                dvs_q <= bus.B;
                p_q   <= '0;
                cnt_q <= '0;
                ov_q  <= 1'b0;
                dz_q  <= 1'b0;
            end
        end else if (state_q == CALC) begin
            dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
            p_q   <= p_next;
            q_q   <= q_next;
            cnt_q <= cnt_q + 5'd1;
            // Overflow means the quotient does not fit the multiplier's 8-bit operand.
            if (last_iter) begin
                r_q  <= p_next[DIVISOR_W-1:0];
                ov_q <= |q_next[DIVIDEND_W-1:DIVISOR_W];
                dz_q <= 1'b0;
            end
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.Q     = q_q;
    assign bus.R     = r_q;
    assign bus.ov    = ov_q;
    assign bus.dz    = dz_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_chia8.sv
// Directed bench for chia8: latency, results, flags, ignored starts, reset abort
// and back-to-back operation, with an expected-result queue checked on done.
module tb_chia8;
    import chia8_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    chia8_if bus ();

    chia8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // {Q, R, ov, dz}
    logic [25:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_result(input logic [15:0] q, input logic [7:0] r, input logic ov, input logic dz);
        exp_q.push_back({q, r, ov, dz});
    endtask

    task automatic score(input string tag);
        logic [25:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " Q"},  {16'd0, bus.Q},      {16'd0, e[25:10]});
            check({tag, " R"},  {24'd0, bus.R},      {24'd0, e[9:2]});
            check({tag, " ov"}, {31'd0, bus.ov},     {31'd0, e[1]});
            check({tag, " dz"}, {31'd0, bus.dz},     {31'd0, e[0]});
        end
    endtask

    // Called at #1 after the start edge (cycle 1); returns the cycle done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic eov, input logic edz, input int elat);
        int lat;
        expect_result(eq, er, eov, edz);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        check({tag, " latency"}, lat, elat);
        score(tag);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, " idle_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [15:0] rq;
        logic        saw_done;
        int          lat;

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst Q",    {16'd0, bus.Q},    32'd0);
        check("rst R",    {24'd0, bus.R},    32'd0);
        check("rst ov",   {31'd0, bus.ov},   32'd0);
        check("rst dz",   {31'd0, bus.dz},   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_div("1000/7",    16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 1'b0, 17);
        do_div("FFFF/1",    16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b1, 1'b0, 17);
        do_div("255/255",   16'd255,   8'd255, 16'd1,     8'd0,   1'b0, 1'b0, 17);
        do_div("200/0",     16'd200,   8'd0,   16'hFFFF,  8'd200, 1'b1, 1'b1, 1);
        do_div("65535/255", 16'd65535, 8'd255, 16'd257,   8'd0,   1'b1, 1'b0, 17);
        do_div("12345/100", 16'd12345, 8'd100, 16'd123,   8'd45,  1'b0, 1'b0, 17);
        do_div("7/9",       16'd7,     8'd9,   16'd0,     8'd7,   1'b0, 1'b0, 17);
        do_div("dz clear",  16'd256,   8'd2,   16'd128,   8'd0,   1'b0, 1'b0, 17);

        // Starts during CALC and during the DONE cycle must be ignored.
        expect_result(16'd166, 8'd2, 1'b0, 1'b0);
        bus.A     = 16'd500;
        bus.B     = 8'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == 5 || c == 17) begin
                bus.start = 1'b1;
                bus.A     = 16'd9;
                bus.B     = 8'd2;
            end
            if (c == 6 || c == 18) begin
                bus.start = 1'b0;
            end
            if (c == 2) begin
                check("ign busy_k1", {31'd0, bus.busy}, 32'd1);
            end
            if (c == 17) begin
                check("ign done", {31'd0, bus.done}, 32'd1);
                score("ign 500/3");
            end
            if (c == 18) begin
                check("ign busy_drop", {31'd0, bus.busy}, 32'd0);
                check("ign done_drop", {31'd0, bus.done}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        check("ign still_idle", {31'd0, bus.busy}, 32'd0);

        // Reset mid-CALC clears everything at once and suppresses done.
        bus.A     = 16'd1000;
        bus.B     = 8'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort Q",    {16'd0, bus.Q},    32'd0);
        check("abort R",    {24'd0, bus.R},    32'd0);
        check("abort ov",   {31'd0, bus.ov},   32'd0);
        check("abort dz",   {31'd0, bus.dz},   32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                rst_n = 1'b1;
            end
            if (bus.done) begin
                saw_done = 1'b1;
            end
        end
        check("abort no_done", {31'd0, saw_done}, 32'd0);
        do_div("100/10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 1'b0, 17);

        // Start held high through DONE is taken at the first IDLE edge.
        expect_result(16'd1, 8'd0, 1'b0, 1'b0);
        expect_result(16'd123, 8'd45, 1'b0, 1'b0);
        bus.A     = 16'd255;
        bus.B     = 8'd255;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.A = 16'd12345;
        bus.B = 8'd100;
        for (int c = 2; c <= 19; c++) begin
            @(posedge clk);
            #1;
            if (c == 17) begin
                check("b2b done1", {31'd0, bus.done}, 32'd1);
                score("b2b 255/255");
            end
            if (c == 18) begin
                check("b2b idle_gap", {31'd0, bus.busy}, 32'd0);
            end
            if (c == 19) begin
                check("b2b accepted", {31'd0, bus.busy}, 32'd1);
            end
        end
        bus.start = 1'b0;
        wait_done(lat);
        check("b2b latency2", lat, 17);
        score("b2b 12345/100");
        @(posedge clk);
        #1;

        // Random operands; expectations come from the native / and % operators.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            rq = ra / {8'd0, rb};
            do_div("rand", ra, rb, rq, 8'(ra % {8'd0, rb}), (rq > 16'd255), 1'b0, 17);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
